// File: rtl/dc_ipu_coord_gen_if.sv
// +----------------------------------------------------------------------------+
// | dc_ipu_coord_gen_if : frame config, coordinate beat and status bundle      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface dc_ipu_coord_gen_if #(
  parameter int COORD_WIDTH = 12,
  parameter int COEFF_WIDTH = 8,
  parameter int STEP_WIDTH  = COORD_WIDTH + COEFF_WIDTH
);
  logic                   start;
  logic [COORD_WIDTH-1:0] dst_width;
  logic [COORD_WIDTH-1:0] dst_height;
  logic [COORD_WIDTH-1:0] src_width;
  logic [COORD_WIDTH-1:0] src_height;
  logic [STEP_WIDTH-1:0]  step_x;
  logic [STEP_WIDTH-1:0]  step_y;
  logic                   out_valid;
  logic                   out_ready;
  logic [COORD_WIDTH-1:0] src_x;
  logic [COORD_WIDTH-1:0] src_y;
  logic [COEFF_WIDTH-1:0] coeff_x;
  logic [COEFF_WIDTH-1:0] coeff_y;
  logic                   eol;
  logic                   eof;
  logic                   busy;
  logic                   done;

  // Generator side: consumes config and ready, produces beats and status.
  modport master (
    input  start, dst_width, dst_height, src_width, src_height,
           step_x, step_y, out_ready,
    output out_valid, src_x, src_y, coeff_x, coeff_y, eol, eof, busy, done
  );

  modport slave (
    output start, dst_width, dst_height, src_width, src_height,
           step_x, step_y, out_ready,
    input  out_valid, src_x, src_y, coeff_x, coeff_y, eol, eof, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/dc_ipu_coord_gen.sv
// +----------------------------------------------------------------------------+
// | dc_ipu_coord_gen : raster-order DDA source coordinate/coefficient sequencer |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dc_ipu_coord_gen #(
  parameter int COORD_WIDTH = 12,
  parameter int COEFF_WIDTH = 8,
  parameter int STEP_WIDTH  = COORD_WIDTH + COEFF_WIDTH
) (
  input  logic                 clk,
  input  logic                 clr,
  dc_ipu_coord_gen_if.master   bus
);

  localparam int ACC_W = COORD_WIDTH + COEFF_WIDTH + 1;
  localparam int INT_W = ACC_W - COEFF_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [COORD_WIDTH-1:0] dst_w_q, dst_w_d, dst_h_q, dst_h_d;
  logic [COORD_WIDTH-1:0] src_w_q, src_w_d, src_h_q, src_h_d;
  logic [STEP_WIDTH-1:0]  step_x_q, step_x_d, step_y_q, step_y_d;
  logic [COORD_WIDTH-1:0] dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [ACC_W-1:0]       acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                   out_valid_q, out_valid_d;
  logic [COORD_WIDTH-1:0] src_x_q, src_x_d, src_y_q, src_y_d;
  logic [COEFF_WIDTH-1:0] coeff_x_q, coeff_x_d, coeff_y_q, coeff_y_d;
  logic                   eol_q, eol_d, eof_q, eof_d;
  logic                   busy_q, busy_d, done_q, done_d;

  logic                   load_beat;
  logic [COORD_WIDTH-1:0] n_x, n_y;
  logic [ACC_W-1:0]       n_ax, n_ay;
  logic [COORD_WIDTH-1:0] lim_w, lim_h, w_m1, h_m1;
  logic                   n_eol;

  function automatic logic [COORD_WIDTH-1:0] clamp_coord(
    input logic [ACC_W-1:0]       acc,
    input logic [COORD_WIDTH-1:0] lim
  );
    logic [INT_W-1:0]       ip;
    logic [COORD_WIDTH-1:0] lim_m1;
    ip     = acc[ACC_W-1:COEFF_WIDTH];
    lim_m1 = lim - COORD_WIDTH'(1);
    if (lim == '0) begin
      return '0;
    end else if (ip > {1'b0, lim_m1}) begin
      return lim_m1;
    end else begin
      return ip[COORD_WIDTH-1:0];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    dst_w_d     = dst_w_q;
    dst_h_d     = dst_h_q;
    src_w_d     = src_w_q;
    src_h_d     = src_h_q;
    step_x_d    = step_x_q;
    step_y_d    = step_y_q;
    dst_x_d     = dst_x_q;
    dst_y_d     = dst_y_q;
    acc_x_d     = acc_x_q;
    acc_y_d     = acc_y_q;
    out_valid_d = out_valid_q;
    src_x_d     = src_x_q;
    src_y_d     = src_y_q;
    coeff_x_d   = coeff_x_q;
    coeff_y_d   = coeff_y_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    load_beat   = 1'b0;
    n_x         = dst_x_q;
    n_y         = dst_y_q;
    n_ax        = acc_x_q;
    n_ay        = acc_y_q;
    lim_w       = src_w_q;
    lim_h       = src_h_q;
    w_m1        = dst_w_q - COORD_WIDTH'(1);
    h_m1        = dst_h_q - COORD_WIDTH'(1);
    n_eol       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          dst_w_d  = bus.dst_width;
          dst_h_d  = bus.dst_height;
          src_w_d  = bus.src_width;
          src_h_d  = bus.src_height;
          step_x_d = bus.step_x;
          step_y_d = bus.step_y;
          busy_d   = 1'b1;
          if (bus.dst_width == '0 || bus.dst_height == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d     = ST_RUN;
            out_valid_d = 1'b1;
            load_beat   = 1'b1;
            n_x         = '0;
            n_y         = '0;
            n_ax        = '0;
            n_ay        = '0;
            // First beat is built from the live inputs being latched this edge.
            lim_w       = bus.src_width;
            lim_h       = bus.src_height;
            w_m1        = bus.dst_width - COORD_WIDTH'(1);
            h_m1        = bus.dst_height - COORD_WIDTH'(1);
          end
        end
      end

      ST_RUN: begin
        busy_d = 1'b1;
        if (out_valid_q && bus.out_ready) begin
          if (eof_q) begin
            state_d     = ST_DONE;
            out_valid_d = 1'b0;
            eol_d       = 1'b0;
            eof_d       = 1'b0;
            done_d      = 1'b1;
          end else begin
            load_beat = 1'b1;
            if (eol_q) begin
              n_x  = '0;
              n_ax = '0;
              n_y  = dst_y_q + COORD_WIDTH'(1);
              n_ay = acc_y_q + ACC_W'(step_y_q);
            end else begin
              n_x  = dst_x_q + COORD_WIDTH'(1);
              n_ax = acc_x_q + ACC_W'(step_x_q);
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (load_beat) begin
      n_eol     = (n_x == w_m1);
      dst_x_d   = n_x;
      dst_y_d   = n_y;
      acc_x_d   = n_ax;
      acc_y_d   = n_ay;
      src_x_d   = clamp_coord(n_ax, lim_w);
      src_y_d   = clamp_coord(n_ay, lim_h);
      coeff_x_d = n_ax[COEFF_WIDTH-1:0];
      coeff_y_d = n_ay[COEFF_WIDTH-1:0];
      eol_d     = n_eol;
      eof_d     = n_eol && (n_y == h_m1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      dst_w_q     <= '0;
      dst_h_q     <= '0;
      src_w_q     <= '0;
      src_h_q     <= '0;
      step_x_q    <= '0;
      step_y_q    <= '0;
      dst_x_q     <= '0;
      dst_y_q     <= '0;
      acc_x_q     <= '0;
      acc_y_q     <= '0;
      out_valid_q <= 1'b0;
      src_x_q     <= '0;
      src_y_q     <= '0;
      coeff_x_q   <= '0;
      coeff_y_q   <= '0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      dst_w_q     <= dst_w_d;
      dst_h_q     <= dst_h_d;
      src_w_q     <= src_w_d;
      src_h_q     <= src_h_d;
      step_x_q    <= step_x_d;
      step_y_q    <= step_y_d;
      dst_x_q     <= dst_x_d;
      dst_y_q     <= dst_y_d;
      acc_x_q     <= acc_x_d;
      acc_y_q     <= acc_y_d;
      out_valid_q <= out_valid_d;
      src_x_q     <= src_x_d;
      src_y_q     <= src_y_d;
      coeff_x_q   <= coeff_x_d;
      coeff_y_q   <= coeff_y_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.src_x     = src_x_q;
  assign bus.src_y     = src_y_q;
  assign bus.coeff_x   = coeff_x_q;
  assign bus.coeff_y   = coeff_y_q;
  assign bus.eol       = eol_q;
  assign bus.eof       = eof_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

`default_nettype wire
